// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU decode and the iterative RV32M unit:
// ALU control codes, instruction class codes, M-op funct3 values and FSM states.
package alu_pkg;

    localparam int ALU_CTRL_W = 4;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0101;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b1000;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1001;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1010;

    localparam logic [1:0] S_T = 2'b00;
    localparam logic [1:0] B_T = 2'b01;
    localparam logic [1:0] R_T = 2'b10;
    localparam logic [1:0] I_T = 2'b11;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 multiply/divide datapath: operates on operand magnitudes, one step per
// cycle, and applies the RV32M sign rules and divide corner cases on the way out.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            special,
    output logic            last,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] ONE_X   = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [2*XLEN-1:0] ONE_2X = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2:0]        op_r;
    logic              neg_q_r, neg_r_r, special_r;
    logic [XLEN-1:0]   special_val_r, divisor_r;
    logic [2*XLEN-1:0] prod_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              a_signed_s, b_signed_s, neg_a_s, neg_b_s, div_zero_s, ovf_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, special_val_s;
    logic [XLEN:0]     sum_s, rem_sh_s, trial_s;
    logic [2*XLEN-1:0] step_next_s, mul_full_s;
    logic [XLEN-1:0]   quo_s, rem_s;

    assign a_signed_s = (op == MD_MUL) | (op == MD_MULH) | (op == MD_MULHSU) |
                        (op == MD_DIV) | (op == MD_REM);
    assign b_signed_s = (op == MD_MUL) | (op == MD_MULH) | (op == MD_DIV) | (op == MD_REM);
    assign neg_a_s    = a_signed_s & a[XLEN-1];
    assign neg_b_s    = b_signed_s & b[XLEN-1];
    assign mag_a_s    = neg_a_s ? (~a + ONE_X) : a;
    assign mag_b_s    = neg_b_s ? (~b + ONE_X) : b;
    assign div_zero_s = op[2] & (b == {XLEN{1'b0}});
    assign ovf_s      = ((op == MD_DIV) | (op == MD_REM)) & (a == MIN_INT) & (b == {XLEN{1'b1}});
    assign special    = div_zero_s | ovf_s;
    assign last       = (cnt_r == CNT_W'(1));

    // Corner-case results are known at accept time, so they bypass the iteration.
    always_comb begin
        special_val_s = {XLEN{1'b0}};
        if (div_zero_s) begin
            special_val_s = op[1] ? a : {XLEN{1'b1}};
        end else if (ovf_s) begin
            special_val_s = op[1] ? {XLEN{1'b0}} : MIN_INT;
        end else begin
            special_val_s = {XLEN{1'b0}};
        end
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    always_comb begin
        sum_s       = {1'b0, prod_r[2*XLEN-1:XLEN]} + (prod_r[0] ? {1'b0, divisor_r} : {(XLEN+1){1'b0}});
        rem_sh_s    = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
        trial_s     = rem_sh_s - {1'b0, divisor_r};
        step_next_s = prod_r;
        if (!op_r[2]) begin
            step_next_s = {sum_s, prod_r[XLEN-1:1]};
        end else if (!trial_s[XLEN]) begin
            step_next_s = {trial_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
        end else begin
            step_next_s = {rem_sh_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
        end
    end

    // Sign fixup and result select.
    always_comb begin
        mul_full_s = neg_q_r ? (~prod_r + ONE_2X) : prod_r;
        quo_s      = neg_q_r ? (~prod_r[XLEN-1:0] + ONE_X) : prod_r[XLEN-1:0];
        rem_s      = neg_r_r ? (~prod_r[2*XLEN-1:XLEN] + ONE_X) : prod_r[2*XLEN-1:XLEN];
        result     = {XLEN{1'b0}};
        if (special_r) begin
            result = special_val_r;
        end else begin
            case (op_r)
                MD_MUL:                       result = mul_full_s[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result = mul_full_s[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:              result = quo_s;
                MD_REM, MD_REMU:              result = rem_s;
                default:                      result = {XLEN{1'b0}};
            endcase
        end
    end

    // Operand latch on accept, then iterate while the counter runs down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r          <= 3'b000;
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= {XLEN{1'b0}};
            divisor_r     <= {XLEN{1'b0}};
            prod_r        <= {(2*XLEN){1'b0}};
            cnt_r         <= {CNT_W{1'b0}};
        end else if (start) begin
            op_r          <= op;
            neg_q_r       <= neg_a_s ^ neg_b_s;
            neg_r_r       <= neg_a_s;
            special_r     <= special;
            special_val_r <= special_val_s;
            divisor_r     <= mag_b_s;
            prod_r        <= {{XLEN{1'b0}}, mag_a_s};
            cnt_r         <= CNT_W'(XLEN);
        end else if (step && (cnt_r != {CNT_W{1'b0}})) begin
            prod_r        <= step_next_s;
            cnt_r         <= cnt_r - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_muldiv_controller.sv
// Execute-stage control: combinational ALU decode with illegal-encoding flag, plus
// the IDLE/RUN/DONE sequencer that drives the iterative RV32M unit and the stall.
module alu_muldiv_controller
    import alu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [1:0]        alu_op,
    input  logic [2:0]        func3,
    input  logic [6:0]        func7,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    input  logic              kill,
    output logic [CTRL_W-1:0] alu_ctrl,
    output logic              illegal,
    output logic              is_md,
    output logic              in_ready,
    output logic              stall,
    output logic              md_valid,
    output logic [XLEN-1:0]   md_result
);

    logic [ALU_CTRL_W-1:0] ctrl_s;
    logic                  legal_s, is_md_s, accept_s, special_s, last_s;
    logic [XLEN-1:0]       result_s;
    md_state_e             state_r, state_next_s;
    logic                  md_valid_r;
    logic [XLEN-1:0]       md_result_r;

    assign accept_s  = in_valid & is_md_s & ~kill & (state_r == ST_IDLE);
    assign in_ready  = (state_r == ST_IDLE);
    assign stall     = (in_valid & is_md_s & (state_r == ST_IDLE)) | (state_r == ST_RUN);
    assign illegal   = in_valid & ~legal_s;
    assign is_md     = is_md_s;
    assign alu_ctrl  = CTRL_W'(ctrl_s);
    assign md_valid  = md_valid_r;
    assign md_result = md_result_r;

    // Instruction decode; anything unrecognised falls back to ADD and flags illegal.
    always_comb begin
        ctrl_s  = ALU_ADD;
        legal_s = 1'b0;
        is_md_s = 1'b0;
        case (alu_op)
            S_T: legal_s = 1'b1;
            B_T: begin
                ctrl_s  = ALU_SUB;
                legal_s = 1'b1;
            end
            R_T: begin
                if (func7 == F7_MD) begin
                    is_md_s = 1'b1;
                    legal_s = 1'b1;
                end else if (func7 == F7_BASE) begin
                    legal_s = 1'b1;
                    case (func3)
                        3'b000:  ctrl_s = ALU_ADD;
                        3'b001:  ctrl_s = ALU_SLL;
                        3'b010:  ctrl_s = ALU_SLT;
                        3'b011:  ctrl_s = ALU_SLTU;
                        3'b100:  ctrl_s = ALU_XOR;
                        3'b101:  ctrl_s = ALU_SRL;
                        3'b110:  ctrl_s = ALU_OR;
                        3'b111:  ctrl_s = ALU_AND;
                        default: ctrl_s = ALU_ADD;
                    endcase
                end else if (func7 == F7_ALT) begin
                    case (func3)
                        3'b000: begin
                            ctrl_s  = ALU_SUB;
                            legal_s = 1'b1;
                        end
                        3'b101: begin
                            ctrl_s  = ALU_SRA;
                            legal_s = 1'b1;
                        end
                        default: legal_s = 1'b0;
                    endcase
                end else begin
                    legal_s = 1'b0;
                end
            end
            I_T: begin
                legal_s = 1'b1;
                case (func3)
                    3'b000:  ctrl_s = ALU_ADD;
                    3'b001:  ctrl_s = ALU_SLL;
                    3'b010:  ctrl_s = ALU_SLT;
                    3'b011:  ctrl_s = ALU_SLTU;
                    3'b100:  ctrl_s = ALU_XOR;
                    3'b101:  ctrl_s = func7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl_s = ALU_OR;
                    3'b111:  ctrl_s = ALU_AND;
                    default: ctrl_s = ALU_ADD;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // Sequencer next state; kill overrides everything, including a same-cycle accept.
    always_comb begin
        state_next_s = state_r;
        if (kill) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_next_s = special_s ? ST_DONE : ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DONE: state_next_s = ST_IDLE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Result register: captured as DONE retires, held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_valid_r  <= 1'b0;
            md_result_r <= {XLEN{1'b0}};
        end else if ((state_r == ST_DONE) && !kill) begin
            md_valid_r  <= 1'b1;
            md_result_r <= result_s;
        end else begin
            md_valid_r  <= 1'b0;
        end
    end

    muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept_s),
        .step    (state_r == ST_RUN),
        .op      (func3),
        .a       (op_a),
        .b       (op_b),
        .special (special_s),
        .last    (last_s),
        .result  (result_s)
    );

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Directed bench: decode sweep checked in place, M-op results checked by a
// scoreboard monitor that also verifies the completion cycle.
module tb_alu_muldiv_controller;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n, in_valid, kill;
    logic [1:0]        alu_op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [XLEN-1:0]   op_a, op_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              illegal, is_md, in_ready, stall, md_valid;
    logic [XLEN-1:0]   md_result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   valid_seen = 0;

    alu_muldiv_controller #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .alu_op    (alu_op),
        .func3     (func3),
        .func7     (func7),
        .op_a      (op_a),
        .op_b      (op_b),
        .kill      (kill),
        .alu_ctrl  (alu_ctrl),
        .illegal   (illegal),
        .is_md     (is_md),
        .in_ready  (in_ready),
        .stall     (stall),
        .md_valid  (md_valid),
        .md_result (md_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every md_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && md_valid) begin
            valid_seen++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_md_valid: md_result=%h at cycle %0d, no result expected", md_result, cyc);
            end else begin
                e = sb_q.pop_front();
                if (md_result !== e.res || cyc != e.due) begin
                    errors++;
                    $display("FAIL md_result: got %h at cycle %0d, expected %h at cycle %0d",
                             md_result, cyc, e.res, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_dec(input logic v, input logic [1:0] op, input logic [6:0] f7,
                             input logic [2:0] f3, input logic [3:0] c, input logic ill,
                             input logic md);
        in_valid = v;
        alu_op   = op;
        func7    = f7;
        func3    = f3;
        kill     = 1'b1;
        #1;
        chk("alu_ctrl", 64'(alu_ctrl), 64'(c));
        chk("illegal", 64'(illegal), 64'(ill));
        chk("is_md", 64'(is_md), 64'(md));
    endtask

    task automatic start_md(input logic [2:0] f3, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, output int e0);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        alu_op   = 2'b10;
        func7    = 7'b0000001;
        func3    = f3;
        op_a     = a;
        op_b     = b;
        kill     = 1'b0;
        #1;
        chk("pre_accept_stall", 64'(stall), 64'd1);
        chk("pre_accept_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e0 = cyc;
    endtask

    task automatic run_md(input logic [2:0] f3, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input bit fast);
        int   e0;
        int   n_stall;
        bit   seen;
        exp_t e;
        start_md(f3, a, b, e0);
        e.res = exp;
        e.due = fast ? e0 + 1 : e0 + XLEN + 1;
        sb_q.push_back(e);
        n_stall = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (md_valid) seen = 1'b1;
            else if (stall) n_stall++;
        end
        chk("md_valid_timeout", 64'(seen), 64'd1);
        chk("stall_cycles", 64'(n_stall), fast ? 64'd0 : 64'(XLEN));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int e0;
        int v0;
        rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0;
        alu_op = 2'b00; func3 = 3'b000; func7 = 7'b0000000;
        op_a = '0; op_b = '0;
        #1;
        chk("rst_md_valid", 64'(md_valid), 64'd0);
        chk("rst_md_result", 64'(md_result), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_idle", 64'(stall), 64'd0);
        in_valid = 1'b1; alu_op = 2'b10; func7 = 7'b0000001;
        #1;
        chk("rst_stall_md", 64'(stall), 64'd1);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // decode sweep (kill held so M encodings never start)
        check_dec(1'b1, 2'b00, 7'b0000000, 3'b010, 4'b0000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b01, 7'b0000000, 3'b001, 4'b0001, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b000, 4'b0000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0100000, 3'b000, 4'b0001, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b111, 4'b0010, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b110, 4'b0011, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b100, 4'b0100, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b010, 4'b0101, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b011, 4'b0111, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b001, 4'b1000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000000, 3'b101, 4'b1001, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0100000, 3'b101, 4'b1010, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000010, 3'b000, 4'b0000, 1'b1, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0100000, 3'b001, 4'b0000, 1'b1, 1'b0);
        check_dec(1'b0, 2'b10, 7'b0000010, 3'b000, 4'b0000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b10, 7'b0000001, 3'b100, 4'b0000, 1'b0, 1'b1);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b000, 4'b0000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b100, 4'b0100, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b110, 4'b0011, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b111, 4'b0010, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b010, 4'b0101, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b011, 4'b0111, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b001, 4'b1000, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0000000, 3'b101, 4'b1001, 1'b0, 1'b0);
        check_dec(1'b1, 2'b11, 7'b0100000, 3'b101, 4'b1010, 1'b0, 1'b0);
        in_valid = 1'b0;
        kill = 1'b0;
        #1;
        chk("kill_blocks_accept", 64'(in_ready), 64'd1);

        // iterative ops
        run_md(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_md(3'b001, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_md(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_md(3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_md(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_md(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_md(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_md(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_md(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run_md(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);

        // corner fast paths
        run_md(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_md(3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
        run_md(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_md(3'b111, 32'd5, 32'd0, 32'd5, 1'b1);
        run_md(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_md(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

        // kill mid-RUN
        start_md(3'b000, 32'd5, 32'd6, e0);
        repeat (10) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_in_ready", 64'(in_ready), 64'd1);
        chk("kill_stall", 64'(stall), 64'd0);
        v0 = valid_seen;
        repeat (40) @(posedge clk);
        chk("kill_no_md_valid", 64'(valid_seen), 64'(v0));
        run_md(3'b000, 32'd3, 32'd4, 32'd12, 1'b0);

        // async reset mid-RUN
        start_md(3'b101, 32'd100, 32'd7, e0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_md_valid", 64'(md_valid), 64'd0);
        chk("midrun_rst_md_result", 64'(md_result), 64'd0);
        chk("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        #4;
        rst_n = 1'b1;
        run_md(3'b101, 32'd9, 32'd3, 32'd3, 1'b0);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
